// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants, FSM state type and channel-walk helper for mux_sel_sequencer.
package mux_sel_sequencer_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDwell   = 2'd1,
        StCapture = 2'd2
    } state_e;

    // Lowest enabled channel at or above 'from'; returns NUM_CH when none remains.
    function automatic logic [2:0] next_en_ch(input logic [NUM_CH-1:0] mask,
                                              input logic [2:0]        from);
        logic [2:0] ch;
        ch = 3'(NUM_CH);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                ch = 3'(i);
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_dwell_timer.sv
// Dwell counter for mux_sel_sequencer: counts while enabled, terminal count at DWELL-1.
module mux_sel_sequencer_dwell_timer #(
    parameter int unsigned CW    = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    // A zero dwell still needs one settle cycle before capture.
    localparam int unsigned DWELL_EFF = (DWELL == 0) ? 1 : DWELL;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CW'(DWELL_EFF - 1));

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scans the four channels of a 4:1 mux and returns one captured snapshot per scan.
// Optional channel mask port and skipping enabled by defining MUX_SEQ_MASK_EN.
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_mux_s,
`ifdef MUX_SEQ_MASK_EN
    input  logic [NUM_CH-1:0] i_ch_mask,
`endif
    output logic [1:0]        o_sel,
    output logic              o_en_n,
    output logic              o_busy,
    output logic              o_done,
    output logic [NUM_CH-1:0] o_samples
);

    state_e            r_state, w_state_d;
    logic [1:0]        r_sel, w_sel_d;
    logic              r_en_n, w_en_n_d;
    logic              r_busy, w_busy_d;
    logic              r_done, w_done_d;
    logic [NUM_CH-1:0] r_samples, w_samples_d;
    logic [NUM_CH-1:0] r_mask, w_new_mask;
    logic              w_load_mask;
    logic              w_tc, w_tmr_clr, w_tmr_en;
    logic [2:0]        w_first_ch, w_next_ch;

`ifdef MUX_SEQ_MASK_EN
    assign w_new_mask = i_ch_mask;
`else
    assign w_new_mask = '1;
`endif

    // Bit 2 set means no enabled channel is left (empty mask / past the last one).
    assign w_first_ch = next_en_ch(w_new_mask, 3'd0);
    assign w_next_ch  = next_en_ch(r_mask, {1'b0, r_sel} + 3'd1);

    mux_sel_sequencer_dwell_timer #(
        .CW    (CW),
        .DWELL (DWELL)
    ) u_dwell_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_state_d   = r_state;
        w_sel_d     = r_sel;
        w_en_n_d    = r_en_n;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_samples_d = r_samples;
        w_load_mask = 1'b0;
        w_tmr_clr   = 1'b1;
        w_tmr_en    = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_en_n_d = 1'b1;
                w_busy_d = 1'b0;
                if (i_start && !w_first_ch[2]) begin
                    w_state_d   = StDwell;
                    w_sel_d     = w_first_ch[1:0];
                    w_en_n_d    = 1'b0;
                    w_busy_d    = 1'b1;
                    w_load_mask = 1'b1;
                end
            end
            StDwell: begin
                if (w_tc) begin
                    w_state_d = StCapture;
                end else begin
                    w_tmr_clr = 1'b0;
                    w_tmr_en  = 1'b1;
                end
            end
            StCapture: begin
                w_samples_d[r_sel] = i_mux_s;
                if (!w_next_ch[2]) begin
                    w_state_d = StDwell;
                    w_sel_d   = w_next_ch[1:0];
                end else begin
                    w_done_d = 1'b1;
                    // Continuous restart re-latches the mask and keeps the mux enabled.
                    if (i_continuous && !w_first_ch[2]) begin
                        w_state_d   = StDwell;
                        w_sel_d     = w_first_ch[1:0];
                        w_load_mask = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                        w_en_n_d  = 1'b1;
                        w_busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_en_n_d  = 1'b1;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_sel     <= '0;
            r_en_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_samples <= '0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_sel     <= w_sel_d;
            r_en_n    <= w_en_n_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_samples <= w_samples_d;
            if (w_load_mask) begin
                r_mask <= w_new_mask;
            end
        end
    end

    assign o_sel     = r_sel;
    assign o_en_n    = r_en_n;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_samples = r_samples;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer; captured snapshots are scored against a queue.
// Mask scenarios run only when MUX_SEQ_MASK_EN is defined.
module tb_mux_sel_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       cont  = 1'b0;
    logic [3:0] a     = 4'h0;
    logic [3:0] mk    = 4'hF;
    logic       mux_s;
    logic [1:0] sel;
    logic       en_n, busy, done;
    logic [3:0] samples;

    logic       start2 = 1'b0;
    logic [3:0] a2     = 4'h0;
    logic       mux_s2;
    logic [1:0] sel2;
    logic       en_n2, busy2, done2;
    logic [3:0] samples2;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_samples = 4'h0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_q2[$];

    always #5 clk = ~clk;

    // The mux floats while disabled; the sequencer must never capture that.
    assign mux_s  = en_n  ? 1'bx : a[sel];
    assign mux_s2 = en_n2 ? 1'bx : a2[sel2];

    mux_sel_sequencer #(
        .DWELL (4),
        .CW    (8)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_continuous (cont),
        .i_mux_s      (mux_s),
`ifdef MUX_SEQ_MASK_EN
        .i_ch_mask    (mk),
`endif
        .o_sel        (sel),
        .o_en_n       (en_n),
        .o_busy       (busy),
        .o_done       (done),
        .o_samples    (samples)
    );

    mux_sel_sequencer #(
        .DWELL (0),
        .CW    (8)
    ) u_dut_d0 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start2),
        .i_continuous (1'b0),
        .i_mux_s      (mux_s2),
`ifdef MUX_SEQ_MASK_EN
        .i_ch_mask    (4'hF),
`endif
        .o_sel        (sel2),
        .o_en_n       (en_n2),
        .o_busy       (busy2),
        .o_done       (done2),
        .o_samples    (samples2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [3:0] m);
        int n = 0;
        for (int i = 0; i < 4; i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic int nth_set(input logic [3:0] m, input int n);
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (k == n) return i;
                k++;
            end
        end
        return -1;
    endfunction

    // Start in cycle 0, follow the scan cycle by cycle, score done/samples from the queue.
    task automatic scan(input string tag, input logic [3:0] av, input int per_ch,
                        input int n_scans, input int restart_cyc, input int drop_cyc);
        int         len     = popc(mk) * per_ch;
        int         last    = n_scans * len + 1;
        logic [3:0] exp_s   = (model_samples & ~mk) | (av & mk);
        logic       in_scan;
        logic       exp_done;
        a = av;
        for (int k = 0; k < n_scans; k++) exp_q.push_back(exp_s);
        model_samples = exp_s;
        start = 1'b1;
        for (int c = 1; c <= last + 3; c++) begin
            tick();
            start = (c == restart_cyc);
            if (c == drop_cyc) cont = 1'b0;
            in_scan  = (c < last);
            exp_done = (c > 1) && (c <= last) && (((c - 1) % len) == 0);
            chk({tag, " en_n"}, en_n, !in_scan);
            chk({tag, " busy"}, busy, in_scan);
            if (in_scan) chk({tag, " sel"}, sel, nth_set(mk, ((c - 1) % len) / per_ch));
            chk({tag, " done"}, done, exp_done);
            if (done === 1'b1) begin
                if (exp_q.size() > 0) chk({tag, " samples"}, samples, exp_q.pop_front());
                else chk({tag, " spare done"}, done, 1'b0);
            end
        end
        chk({tag, " pending"}, exp_q.size(), 0);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset sel", sel, 2'd0);
        chk("reset en_n", en_n, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset samples", samples, 4'h0);
        chk("reset en_n d0", en_n2, 1'b1);
        rst = 1'b0;
        tick();

        scan("basic", 4'b1010, 5, 1, -1, -1);
        tick();

        scan("busy_start", 4'b0011, 5, 1, 7, -1);

        cont = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("cont idle en_n", en_n, 1'b1);
            chk("cont idle busy", busy, 1'b0);
        end

        scan("cont", 4'b0110, 5, 2, -1, 30);

        a = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 12; c++) tick();
        chk("rst pre sel", sel, 2'd2);
        rst = 1'b1;
        #1;
        chk("rst sel", sel, 2'd0);
        chk("rst en_n", en_n, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst samples", samples, 4'h0);
        tick();
        rst = 1'b0;
        model_samples = 4'h0;
        for (int c = 0; c < 25; c++) begin
            tick();
            chk("post rst done", done, 1'b0);
            chk("post rst en_n", en_n, 1'b1);
        end

        a2 = 4'b0101;
        exp_q2.push_back(4'b0101);
        start2 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start2 = 1'b0;
            chk("d0 en_n", en_n2, !(c < 9));
            chk("d0 busy", busy2, (c < 9));
            if (c < 9) chk("d0 sel", sel2, (c - 1) / 2);
            chk("d0 done", done2, (c == 9));
            if (done2 === 1'b1 && exp_q2.size() > 0) chk("d0 samples", samples2, exp_q2.pop_front());
        end
        chk("d0 pending", exp_q2.size(), 0);

`ifdef MUX_SEQ_MASK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_samples = 4'h0;
        tick();
        mk = 4'b1001;
        scan("mask1001", 4'b1111, 5, 1, -1, -1);
        mk = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("mask0 en_n", en_n, 1'b1);
            chk("mask0 busy", busy, 1'b0);
            tick();
        end
        mk = 4'hF;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
